// File: rtl/alu_result_fifo.sv
// First-word-fall-through result buffer behind the add/sub ALU; always accepts, drops on overflow.
// Optional statistics counters are enabled with `define ALU_RESULT_FIFO_STATS_EN.
module alu_result_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           res_in,
    input  logic                       res_valid,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    input  logic                       ovf_clr
`ifdef ALU_RESULT_FIFO_STATS_EN
    ,
    input  logic                       stats_clr,
    output logic [15:0]                accepted_cnt,
    output logic [15:0]                dropped_cnt
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic             drop;

    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign dout_valid = !empty;
    assign dout       = empty ? '0 : mem[rd_ptr];

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign pop  = dout_valid && dout_ready;
    assign push = res_valid && (!full || pop);
    assign drop = res_valid && full && !pop;

    // NOTE: storage carries no reset; validity is tracked by count and pointers alone.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= res_in;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            // A new drop outranks a clear request in the same cycle.
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

`ifdef ALU_RESULT_FIFO_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            accepted_cnt <= '0;
            dropped_cnt  <= '0;
        end else begin
            if (push && accepted_cnt != 16'hFFFF) accepted_cnt <= accepted_cnt + 16'd1;
            if (drop && dropped_cnt  != 16'hFFFF) dropped_cnt  <= dropped_cnt + 16'd1;
        end
    end
`endif

    a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= CW'(DEPTH));
    a_full_empty:  assert property (@(posedge clk) disable iff (rst) !(full && empty));
    a_valid:       assert property (@(posedge clk) disable iff (rst) dout_valid == !empty);

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed self-checking bench for alu_result_fifo (WIDTH=6, DEPTH=8).
// Expected values are hand-computed; stats checks apply when ALU_RESULT_FIFO_STATS_EN is defined.
module tb_alu_result_fifo;

    localparam int WIDTH = 6;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] res_in;
    logic             res_valid;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic [3:0]       count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             ovf_clr;
`ifdef ALU_RESULT_FIFO_STATS_EN
    logic             stats_clr;
    logic [15:0]      accepted_cnt;
    logic [15:0]      dropped_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .res_in     (res_in),
        .res_valid  (res_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
`ifdef ALU_RESULT_FIFO_STATS_EN
        ,
        .stats_clr    (stats_clr),
        .accepted_cnt (accepted_cnt),
        .dropped_cnt  (dropped_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs are driven at the falling edge; outputs are sampled at the next falling edge.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [WIDTH-1:0] v);
        res_valid  = 1'b1;
        res_in     = v;
        dout_ready = 1'b0;
        cycle();
        res_valid  = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [WIDTH-1:0] exp);
        check({tag, "_dout"}, 32'(dout), 32'(exp));
        check({tag, "_valid"}, 32'(dout_valid), 32'd1);
        dout_ready = 1'b1;
        cycle();
        dout_ready = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        res_valid  = 1'b1;
        res_in     = 6'h15;
        dout_ready = 1'b0;
        ovf_clr    = 1'b0;
`ifdef ALU_RESULT_FIFO_STATS_EN
        stats_clr  = 1'b0;
`endif
        @(negedge clk);
        cycle();
        cycle();
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst       = 1'b0;
        res_valid = 1'b0;

        // Single pass: FWFT latency of one edge, then drain.
        push(6'h03);
        check("one_dout", 32'(dout), 32'h03);
        check("one_valid", 32'(dout_valid), 32'd1);
        check("one_count", 32'(count), 32'd1);
        dout_ready = 1'b1;
        cycle();
        dout_ready = 1'b0;
        check("one_empty", 32'(empty), 32'd1);
        check("one_dout0", 32'(dout), 32'd0);

        // Fill from pointer 1 so the pointers wrap.
        for (int i = 1; i <= 8; i++) push(WIDTH'(i));
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd8);
        for (int i = 1; i <= 3; i++) pop_check("wrap_pop", WIDTH'(i));
        check("wrap_count5", 32'(count), 32'd5);
        for (int i = 9; i <= 11; i++) push(WIDTH'(i));
        check("wrap_full", 32'(full), 32'd1);

        // Full with simultaneous push and pop.
        res_valid  = 1'b1;
        res_in     = 6'h2A;
        dout_ready = 1'b1;
        check("pp_head", 32'(dout), 32'h04);
        cycle();
        res_valid  = 1'b0;
        dout_ready = 1'b0;
        check("pp_count", 32'(count), 32'd8);
        check("pp_ovf", 32'(overflow), 32'd0);
        for (int i = 5; i <= 11; i++) pop_check("pp_pop", WIDTH'(i));
        pop_check("pp_last", 6'h2A);
        check("pp_empty", 32'(empty), 32'd1);

        // Overflow: drop, clear alone, clear against a new drop.
        for (int i = 0; i < 8; i++) push(WIDTH'(6'h10 + i));
        push(6'h3F);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd8);
        ovf_clr = 1'b1;
        cycle();
        check("ovf_clr", 32'(overflow), 32'd0);
        res_valid = 1'b1;
        res_in    = 6'h3F;
        cycle();
        res_valid = 1'b0;
        ovf_clr   = 1'b0;
        check("ovf_prio", 32'(overflow), 32'd1);
`ifdef ALU_RESULT_FIFO_STATS_EN
        check("st_drop", 32'(dropped_cnt), 32'd2);
        check("st_acc", 32'(accepted_cnt), 32'd21);
`endif
        for (int i = 0; i < 8; i++) pop_check("ovf_pop", WIDTH'(6'h10 + i));
        check("ovf_empty", 32'(empty), 32'd1);

        // Reset mid-operation.
        for (int i = 0; i < 5; i++) push(WIDTH'(6'h20 + i));
        check("mid_count5", 32'(count), 32'd5);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("mid_count", 32'(count), 32'd0);
        check("mid_valid", 32'(dout_valid), 32'd0);
        check("mid_ovf", 32'(overflow), 32'd0);
        push(6'h11);
        check("mid_dout", 32'(dout), 32'h11);
        check("mid_cnt1", 32'(count), 32'd1);
`ifdef ALU_RESULT_FIFO_STATS_EN
        check("mid_acc", 32'(accepted_cnt), 32'd1);
        check("mid_drop", 32'(dropped_cnt), 32'd0);
        stats_clr = 1'b1;
        push(6'h12);
        stats_clr = 1'b0;
        check("sclr_acc", 32'(accepted_cnt), 32'd0);
        check("sclr_count", 32'(count), 32'd2);
`endif

        // Ready while empty has no effect.
        dout_ready = 1'b1;
        cycle();
        cycle();
        dout_ready = 1'b0;
        check("idle_empty", 32'(empty), 32'd1);
        dout_ready = 1'b1;
        cycle();
        dout_ready = 1'b0;
        check("idle_count", 32'(count), 32'd0);
        check("idle_dout", 32'(dout), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
